// File: rtl/pll_lock_pkg.sv
// Shared definitions for the PLL lock / reset sequencing blocks: state encoding,
// default cycle constants and the phase-counter width helper.
`timescale 1ns/1ps
package pll_lock_pkg;

    localparam logic [1:0] WAIT_LOCK = 2'd0;
    localparam logic [1:0] STABLE    = 2'd1;
    localparam logic [1:0] HOLD      = 2'd2;
    localparam logic [1:0] RUN       = 2'd3;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_HOLD_CYCLES   = 16;
    localparam int DEF_LOSS_CNT_W    = 8;

    // Phase counter must hold max(stable, hold) - 1; never narrower than one bit.
    function automatic int cnt_width(input int stable_cycles, input int hold_cycles);
        int m;
        m = (stable_cycles > hold_cycles) ? stable_cycles : hold_cycles;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/lock_sync.sv
// Flop-chain synchroniser for a single asynchronous status input.
`timescale 1ns/1ps
module lock_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic async_in,
    output logic sync_out
);

    logic [STAGES-1:0] sync_p;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[STAGES-2:0], async_in};
        end
    end

    assign sync_out = sync_p[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Qualifies the PLL lock flag, releases a clean system reset after a stable+hold
// interval, and re-asserts it (recording the event) whenever lock drops in RUN.
`timescale 1ns/1ps
module pll_lock_reset_seq
    import pll_lock_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int LOSS_CNT_W    = DEF_LOSS_CNT_W
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  locked,
    input  logic                  clear_status,
    output logic                  sys_reset_n,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    localparam int CNT_W = cnt_width(STABLE_CYCLES, HOLD_CYCLES);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || HOLD_CYCLES < 1 || LOSS_CNT_W < 1) begin : g_bad_params
        $error("pll_lock_reset_seq: illegal parameters (SYNC_STAGES>=2, STABLE_CYCLES>=1, HOLD_CYCLES>=1 required)");
    end

    logic             locked_s;
    logic [1:0]       state_q;
    logic [1:0]       next_state;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             loss_event;

    lock_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clock    (clock),
        .reset_n  (reset_n),
        .async_in (locked),
        .sync_out (locked_s)
    );

    // A drop of locked_s takes priority over any phase-complete condition.
    always_comb begin
        next_state = state_q;
        cnt_d      = cnt_q;
        loss_event = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                if (locked_s) begin
                    next_state = STABLE;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                    cnt_d      = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    next_state = HOLD;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD: begin
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                    cnt_d      = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    next_state = RUN;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!locked_s) begin
                    next_state = WAIT_LOCK;
                    loss_event = 1'b1;
                end
            end
            default: begin
                next_state = WAIT_LOCK;
                cnt_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= WAIT_LOCK;
            cnt_q       <= '0;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
        end else begin
            state_q     <= next_state;
            cnt_q       <= cnt_d;
            sys_reset_n <= (next_state == RUN);
            ready       <= (next_state == RUN);
        end
    end

    // A loss on the same edge as clear_status restarts the count at one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end else if (loss_event) begin
            lock_lost <= 1'b1;
            if (clear_status) begin
                loss_count <= LOSS_CNT_W'(1);
            end else if (!(&loss_count)) begin
                loss_count <= loss_count + LOSS_CNT_W'(1);
            end
        end else if (clear_status) begin
            lock_lost  <= 1'b0;
            loss_count <= '0;
        end
    end

endmodule
